// File: rtl/vga_stream_pkg.sv
// Shared types and constants for the SRAM-to-VGA RGB frame streamer.
// Two pixels are packed into three 16-bit words: {R0,G0} {B0,R1} {G1,B1}.
package vga_stream_pkg;

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, FINISH} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int WORDS_PER_PAIR  = 3;
  localparam int PIXELS_PER_PAIR = 2;
  localparam int PIX_DIV         = 2;

  localparam int DEF_AW           = 18;
  localparam int DEF_IMAGE_WIDTH  = 320;
  localparam int DEF_IMAGE_HEIGHT = 240;
  // The default frame ends exactly on the last SRAM word.
  localparam int DEF_RGB_BASE     = 146944;

  function automatic int frame_words(input int w, input int h);
    return w * h * WORDS_PER_PAIR / PIXELS_PER_PAIR;
  endfunction

endpackage

// File: rtl/vga_frame_streamer_if.sv
// Control, SRAM read port and VGA pixel bus of the frame streamer.
// The slave modport is the streamer; master is whoever drives start and the SRAM data.
interface vga_frame_streamer_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic          start;
  logic          done;
  logic          busy;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata;
  logic          vgastart;
  logic [7:0]    r;
  logic [7:0]    g;
  logic [7:0]    b;

  modport slave (
    input  start, sram_rdata,
    output done, busy, sram_raddr, vgastart, r, g, b
  );

  modport master (
    output start, sram_rdata,
    input  done, busy, sram_raddr, vgastart, r, g, b
  );
endinterface

// File: rtl/rgb_pair_unpacker.sv
// Splits one buffered three-word group into its two RGB pixels.
module rgb_pair_unpacker
  import vga_stream_pkg::*;
(
  input  logic [15:0] w0,
  input  logic [15:0] w1,
  input  logic [15:0] w2,
  output rgb_t        pix0,
  output rgb_t        pix1
);

  assign pix0 = {w0, w1[15:8]};
  assign pix1 = {w1[7:0], w2};

endmodule

// File: rtl/vga_frame_streamer.sv
// Streams a packed RGB frame from SRAM to the VGA controller, one pixel per two clocks.
// ph is the cycle position inside a 4-cycle pair slot, counted from the cycle after start.
module vga_frame_streamer
  import vga_stream_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = 16,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int RGB_BASE     = DEF_RGB_BASE
) (
  input logic                 clk,
  input logic                 reset,
  vga_frame_streamer_if.slave bus
);

  localparam int NPIX   = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int NWORDS = frame_words(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int CW     = $clog2(NPIX + 1);

  localparam logic [AW-1:0] BASE     = AW'(RGB_BASE);
  localparam logic [AW-1:0] LAST     = AW'(RGB_BASE + NWORDS - 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(NPIX - 1);

  state_t        state;
  logic [1:0]    ph;
  logic [CW-1:0] pix_cnt;
  logic [DW-1:0] nxt0, nxt1;
  logic [DW-1:0] cur0, cur1, cur2;
  rgb_t          pix0, pix1;
  logic          active;

  assign active = (state == PREFETCH) || (state == STREAM);

  rgb_pair_unpacker u_unpack (
    .w0  (cur0),
    .w1  (cur1),
    .w2  (cur2),
    .pix0(pix0),
    .pix1(pix1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ph             <= '0;
      pix_cnt        <= '0;
      nxt0           <= '0;
      nxt1           <= '0;
      cur0           <= '0;
      cur1           <= '0;
      cur2           <= '0;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.vgastart   <= 1'b0;
      {bus.r, bus.g, bus.b} <= '0;
      bus.sram_raddr <= BASE;
    end else begin
      bus.done     <= 1'b0;
      bus.vgastart <= 1'b0;

      // Reads go out on slot phases 0..2; data lands one cycle later. The
      // current pair is replaced only after its second pixel is registered.
      if (active) begin
        ph <= ph + 2'd1;
        if (ph != 2'd2 && bus.sram_raddr != LAST)
          bus.sram_raddr <= bus.sram_raddr + 1'b1;
        case (ph)
          2'd1:    nxt0 <= bus.sram_rdata;
          2'd2:    nxt1 <= bus.sram_rdata;
          2'd3:    {cur0, cur1, cur2} <= {nxt0, nxt1, bus.sram_rdata};
          default: ;
        endcase
      end

      case (state)
        IDLE: if (bus.start) begin
          state          <= PREFETCH;
          bus.busy       <= 1'b1;
          ph             <= '0;
          pix_cnt        <= '0;
          bus.sram_raddr <= BASE;
        end
        PREFETCH: begin
          if (ph == 2'd3)
            bus.vgastart <= 1'b1;
          else if (ph == 2'd0 && bus.vgastart) begin
            state <= STREAM;
            {bus.r, bus.g, bus.b} <= pix0;
          end
        end
        STREAM: begin
          case (ph)
            2'd0: begin
              if (pix_cnt == PIX_LAST) begin
                state    <= FINISH;
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
                {bus.r, bus.g, bus.b} <= '0;
              end else begin
                pix_cnt <= pix_cnt + 1'b1;
                {bus.r, bus.g, bus.b} <= pix0;
              end
            end
            2'd2: begin
              pix_cnt <= pix_cnt + 1'b1;
              {bus.r, bus.g, bus.b} <= pix1;
            end
            default: ;
          endcase
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vga_frame_streamer.md
Name: vga_frame_streamer

Overview:
- Reads the decoded RGB frame from the SRAM read port and streams it to the VGA controller interface (vgastart, r, g, b).
- This is the consuming end of the RGB image that the decompressor writes into SRAM.
- Used by decompressor_top after decode completes, and also standalone in SRAM_Emulator/VGA_Emulator benches.
- Pixel rate is one pixel per 2 clocks (25 MHz pixel rate from the 50 MHz clk).

Parameters:
AW, 18, SRAM address width
DW, 16, SRAM data width (fixed at 16 by the packing format)
IMAGE_WIDTH, 320, pixels per line
IMAGE_HEIGHT, 240, lines per frame; IMAGE_WIDTH*IMAGE_HEIGHT must be even
RGB_BASE, 146944, SRAM word address of the first RGB word

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to stream one frame
done  output  1  single-cycle pulse after the last pixel of the frame
busy  output  1  high from the cycle after start is accepted until done
sram_raddr  output  AW  SRAM read address
sram_rdata  input  DW  SRAM read data, valid the cycle after sram_raddr is presented
vgastart  output  1  single-cycle frame-start pulse to the VGA controller
r  output  8  red component, registered
g  output  8  green component, registered
b  output  8  blue component, registered

Behaviour:
- Interface fixed: one clock clk; reset is asynchronous and active-high.
- Reset values: done=0, busy=0, vgastart=0, r=g=b=0, sram_raddr=RGB_BASE, FSM=IDLE.
- Packing: 3 words hold 2 pixels. Define w0, w1, w2 as the three words of a pair.
  - Word0 = {R0,G0}
  - Word1 = {B0,R1}
  - Word2 = {G1,B1}
  - Frame occupies NWORDS = W*H*3/2 words from RGB_BASE.
  - Defaults end exactly at 2^18-1.
- FSM states: IDLE, PREFETCH, STREAM, FINISH.
- IDLE:
  - start high at edge T moves the FSM to PREFETCH.
  - Reads issue at RGB_BASE, +1, +2 in cycles T+1..T+3.
- PREFETCH:
  - Data captured in cycles T+2..T+4.
  - vgastart is high during cycle T+5 only, then the FSM enters STREAM.
- STREAM:
  - Pixel k is driven on r/g/b during cycles T+6+2k and T+7+2k.
  - Each 4-cycle pixel-pair slot issues the 3 reads for the next pair.
  - A two-pair buffer (current and next) guarantees no gap and no stall.
- sram_raddr:
  - Increments by 1 per read and never exceeds RGB_BASE+NWORDS-1.
  - When not reading, it holds its last value; there is no read enable, so reads are side-effect free.
- FINISH:
  - After the second cycle of the last pixel, r=g=b=0.
  - done pulses during cycle T+6+2N (N = W*H).
  - busy drops in the same cycle; the FSM returns to IDLE.
- start while busy is ignored. A start in the same cycle as done is also ignored; the next frame needs start in IDLE.
- Outside STREAM, r=g=b=0.
- Reset mid-frame: immediate return to all reset values, no done pulse, sram_raddr=RGB_BASE.
- Address arithmetic: AW-bit unsigned; the pixel counter is sized to ceil(log2(W*H+1)).

Decomposition:
- Shared package vga_stream_pkg:
  - FSM state enum.
  - WORDS_PER_PAIR=3, PIXELS_PER_PAIR=2, PIX_DIV=2.
  - Default RGB_BASE and image-size constants (shared with param.v values).
- Sub-module rgb_pair_unpacker: takes three 16-bit words and outputs {R0,G0,B0} and {R1,G1,B1}. It is purely combinational, instantiated once on the buffered pair.

Test Plan:
1. W=4, H=2, RGB_BASE=16, mem[16..27]=0x0102,0x0304,0x0506,...
   - start at T -> vgastart at T+5.
   - Pixel0 R=01,G=02,B=03 on T+6..T+7; pixel1 R=04,G=05,B=06 on T+8..T+9.
   - done at T+22.
2. Same image: check sram_raddr covers 16..27 exactly once each, in order, never exceeding 27. Each pixel holds exactly 2 cycles with no gap between pixels 1->2 (pair boundary).
3. start re-pulsed at T+10 mid-frame -> ignored. Frame and done timing are identical to scenario 1; busy stays high.
4. reset asserted asynchronously at T+12 (mid-edge) -> r/g/b/vgastart/busy go 0 immediately, no done. A new start then reproduces scenario 1 output.
5. Default 320x240, RGB_BASE=146944:
   - done exactly 6+2*76800 cycles after start.
   - Last read address 262143.
   - VGA_Emulator captures 76800 pixels matching the packed file.
6. Back-to-back: start in the cycle after done -> second frame identical to the first, vgastart again 5 cycles later.
